pwl_lut_eval: RTL and testbench

Piecewise-linear evaluator for the nonlinear approximation engine. It accepts an unsigned input sample, fetches that segment's {slope, intercept} coefficient word from the dual-port coefficient BRAM through read port A, and computes y = intercept + slope·frac with signed saturation. It sits directly downstream of the coefficient BRAM: it drives the BRAM's port-A controls and consumes the BRAM's registered output. It processes one sample at a time through a five-state FSM with valid/ready handshakes on both sides.

---
 rtl/pwl_lut_eval.sv | 145 ++++++++++++++
 tb/tb_pwl_lut_eval.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pwl_lut_eval.sv
// pwl_lut_eval: piecewise-linear evaluator driving a coefficient BRAM (port A).
// Computes y = intercept + (slope * frac) >>> FRAC_W with signed saturation,
// one sample at a time: IDLE -> FETCH -> LATCH -> CALC -> HOLD.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o, x_i   input sample handshake (unsigned sample)
//   out_valid_o/out_ready_i      result handshake
//   y_o, sat_o                   signed result, saturation flag
//   bram_*_o, bram_dout_i        BRAM port-A controls and registered read data
module pwl_lut_eval #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_LINES = 4,
    localparam int unsigned RAM_WIDTH = 2 * DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     x_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     y_o,
    output logic                  sat_o,
    output logic [ADDR_LINES-1:0] bram_addr_o,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic                  bram_regce_o,
    output logic                  bram_rstn_o,
    input  logic [RAM_WIDTH-1:0]  bram_dout_i
);

    localparam int unsigned FRAC_W = DATA_W - ADDR_LINES;
    localparam int unsigned PROD_W = DATA_W + FRAC_W + 1;
    localparam int unsigned SUM_W  = DATA_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_CALC  = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_LINES-1:0] idx_q;
    logic [FRAC_W-1:0]     frac_q;
    logic [DATA_W-1:0]     y_q, y_d;
    logic                  sat_q, sat_d;
    logic                  accept;

    logic signed [DATA_W-1:0] slope, intercept;
    logic signed [PROD_W-1:0] slope_x, frac_x, prod, term_full;
    logic signed [SUM_W-1:0]  sum;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid_i) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_CALC;
            S_CALC:  state_d = S_HOLD;
            S_HOLD: begin
                if (out_ready_i) state_d = in_valid_i ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; in_ready is held low during reset so nothing is accepted
    always_comb begin
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        bram_en_o    = 1'b0;
        bram_regce_o = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready_o   = ~rst_i;
            S_FETCH: bram_en_o    = 1'b1;
            S_LATCH: bram_regce_o = 1'b1;
            S_HOLD: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i & ~rst_i;
            end
            default: ;
        endcase
    end

    assign accept = in_valid_i & in_ready_o;

    // Sample capture and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            frac_q <= '0;
            y_q    <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (accept) begin
                idx_q  <= x_i[DATA_W-1 -: ADDR_LINES];
                frac_q <= x_i[FRAC_W-1:0];
            end
            if (state_q == S_CALC) begin
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    // Datapath: frac is zero-extended so the product sign follows slope only
    always_comb begin
        slope     = bram_dout_i[RAM_WIDTH-1:DATA_W];
        intercept = bram_dout_i[DATA_W-1:0];
        slope_x   = PROD_W'(slope);
        frac_x    = PROD_W'(frac_q);
        prod      = slope_x * frac_x;
        term_full = prod >>> FRAC_W;
        // |term| < 2^(DATA_W-1), so truncating to SUM_W keeps its value
        sum       = SUM_W'(intercept) + SUM_W'(term_full);
        sat_d     = 1'b0;
        y_d       = sum[DATA_W-1:0];
        // Overflow iff the two top bits of the widened sum disagree
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            sat_d = 1'b1;
            y_d   = sum[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign y_o         = y_q;
    assign sat_o       = sat_q;
    assign bram_addr_o = idx_q;
    assign bram_we_o   = 1'b0;
    assign bram_rstn_o = ~rst_i;

endmodule

// File: tb/tb_pwl_lut_eval.sv
// Directed bench for pwl_lut_eval with a behavioural two-stage BRAM on port A.
module tb_pwl_lut_eval;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_LINES = 4;
    localparam int unsigned RAM_WIDTH  = 2 * DATA_W;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     x;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     y;
    logic                  sat;
    logic [ADDR_LINES-1:0] bram_addr;
    logic                  bram_en;
    logic                  bram_we;
    logic                  bram_regce;
    logic                  bram_rstn;
    logic [RAM_WIDTH-1:0]  bram_dout;

    logic [RAM_WIDTH-1:0]  mem [16];
    logic [RAM_WIDTH-1:0]  ram_q;

    int n_cmp = 0;
    int n_mis = 0;

    pwl_lut_eval #(.DATA_W(DATA_W), .ADDR_LINES(ADDR_LINES)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .x_i          (x),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .y_o          (y),
        .sat_o        (sat),
        .bram_addr_o  (bram_addr),
        .bram_en_o    (bram_en),
        .bram_we_o    (bram_we),
        .bram_regce_o (bram_regce),
        .bram_rstn_o  (bram_rstn),
        .bram_dout_i  (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM port A: array read on en, output register on regce, reset by rstn
    always @(posedge clk) begin
        if (bram_en) ram_q <= mem[bram_addr];
        if (!bram_rstn)      bram_dout <= '0;
        else if (bram_regce) bram_dout <= ram_q;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One sample with latency checks, optional backpressure in HOLD, then drain
    task automatic run_one(input logic [15:0] xin, input logic [15:0] ey,
                           input logic esat, input int hold);
        int cyc;
        @(negedge clk);
        in_valid  = 1'b1;
        x         = xin;
        out_ready = 1'b0;
        #1 check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("fetch_en", bram_en, 1);
        check("fetch_addr", bram_addr, xin[15:12]);
        check("fetch_nvalid", out_valid, 0);
        @(negedge clk);
        check("latch_en", bram_en, 0);
        check("latch_regce", bram_regce, 1);
        cyc = 2;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 4);
        check("y", y, ey);
        check("sat", sat, esat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_y", y, ey);
            check("bp_ready", in_ready, 0);
            check("bp_en", bram_en, 0);
        end
        out_ready = 1'b1;
        #1 check("hold_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        check("drained", out_valid, 0);
    endtask

    logic [15:0] sx [3];
    logic [15:0] sy [3];

    initial begin
        int n_in, n_out, cyc, last_acc, seen;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[3]  = {16'h0100, 16'h0400};
        mem[15] = {16'h7FFF, 16'h7F00};
        mem[0]  = {16'h8000, 16'h0000};
        mem[5]  = {16'h8000, 16'h8000};
        mem[6]  = {16'hFFFF, 16'h0000};
        ram_q = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_rstn", bram_rstn, 0);
        check("rst_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_sat", sat, 0);
        check("rst_en", bram_en, 0);
        check("rst_regce", bram_regce, 0);
        check("we_tied", bram_we, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        check("idle_rstn", bram_rstn, 1);

        run_one(16'h3800, 16'h0480, 1'b0, 0);   // basic
        run_one(16'hFFFF, 16'h7FFF, 1'b1, 0);   // positive clamp
        run_one(16'h0FFF, 16'h8008, 1'b0, 0);   // negative slope
        run_one(16'h5FFF, 16'h8000, 1'b1, 0);   // negative clamp
        run_one(16'h6001, 16'hFFFF, 1'b0, 0);   // -1/4096 floors to -1
        run_one(16'h3800, 16'h0480, 1'b0, 10);  // backpressure

        // Back-to-back streaming
        sx[0] = 16'h3800; sx[1] = 16'h0FFF; sx[2] = 16'h3800;
        sy[0] = 16'h0480; sy[1] = 16'h8008; sy[2] = 16'h0480;
        n_in = 0; n_out = 0; cyc = 0; last_acc = 0;
        @(negedge clk);
        in_valid = 1'b1; x = sx[0]; out_ready = 1'b1;
        while (n_out < 3 && cyc < 60) begin
            #1;
            if (out_valid) begin
                check("stream_y", y, sy[n_out]);
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (n_in > 0) check("stream_gap", cyc - last_acc, 4);
                last_acc = cyc;
                n_in++;
            end
            @(negedge clk);
            cyc++;
            if (n_in < 3) x = sx[n_in];
            else in_valid = 1'b0;
        end
        check("stream_count", n_out, 3);
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset while in LATCH
        @(negedge clk);
        in_valid = 1'b1; x = 16'h3800;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_regce", bram_regce, 1);
        rst = 1'b1;
        #1 check("mid_rst_ready", in_ready, 0);
        check("mid_rst_rstn", bram_rstn, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_ghost_valid", seen, 0);

        run_one(16'h0FFF, 16'h8008, 1'b0, 0);   // recovers after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
